// File: rtl/wb_write_queue.sv
// In-order write-back queue feeding the register file write port from ALU and load results.
// Optional read-side bypass of pending writes is built when WB_WRITE_QUEUE_BYPASS_EN is defined.
module wb_write_queue #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [ADDRESS_WIDTH-1:0] a_rd,
    input  logic [DATA_WIDTH-1:0]    a_data,
    input  logic                     m_valid,
    output logic                     m_ready,
    input  logic [ADDRESS_WIDTH-1:0] m_rd,
    input  logic [DATA_WIDTH-1:0]    m_data,
    output logic [ADDRESS_WIDTH-1:0] AD3,
    output logic                     WE3,
    output logic [DATA_WIDTH-1:0]    WD3,
    output logic [$clog2(DEPTH):0]   count
`ifdef WB_WRITE_QUEUE_BYPASS_EN
    ,
    input  logic [ADDRESS_WIDTH-1:0] q1_ad,
    input  logic [ADDRESS_WIDTH-1:0] q2_ad,
    output logic                     q1_hit,
    output logic                     q2_hit,
    output logic [DATA_WIDTH-1:0]    q1_data,
    output logic [DATA_WIDTH-1:0]    q2_data
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [ADDRESS_WIDTH-1:0] r_rd   [DEPTH];
    logic [DATA_WIDTH-1:0]    r_data [DEPTH];
    logic [PW-1:0]            r_head;
    logic [PW-1:0]            r_tail;
    logic [CW-1:0]            r_count;

    logic [CW-1:0] w_free;
    logic          w_a_push;
    logic          w_m_push;
    logic          w_deq;
    logic [PW-1:0] w_m_slot;
    logic [CW-1:0] w_enq_n;

    // Ready depends only on registered occupancy; no credit for the pop this cycle.
    assign w_free   = DEPTH_C - r_count;
    assign a_ready  = (w_free >= CW'(1));
    assign m_ready  = (w_free >= CW'(2));

    // Writes to x0 are accepted but never stored.
    assign w_a_push = a_valid && a_ready && (a_rd != '0);
    assign w_m_push = m_valid && m_ready && (m_rd != '0);
    assign w_deq    = (r_count != '0);

    // The load lands behind the ALU entry when both push in one cycle.
    assign w_m_slot = r_tail + PW'(w_a_push);
    assign w_enq_n  = CW'(w_a_push) + CW'(w_m_push);

    // Entry storage; contents past the tail are don't-care so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_a_push) begin
            r_rd[r_tail]   <= a_rd;
            r_data[r_tail] <= a_data;
        end
        if (w_m_push) begin
            r_rd[w_m_slot]   <= m_rd;
            r_data[w_m_slot] <= m_data;
        end
    end

    // Pointer and occupancy update; reset discards all pending entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(w_deq);
            r_tail  <= r_tail + PW'(w_enq_n);
            r_count <= r_count + w_enq_n - CW'(w_deq);
        end
    end

    assign count = r_count;
    assign WE3   = w_deq;
    assign AD3   = w_deq ? r_rd[r_head]   : '0;
    assign WD3   = w_deq ? r_data[r_head] : '0;

`ifdef WB_WRITE_QUEUE_BYPASS_EN
    // Scan oldest to youngest so the youngest match wins.
    function automatic logic [DATA_WIDTH:0] f_lookup(
        input logic [ADDRESS_WIDTH-1:0] q
    );
        logic [DATA_WIDTH:0] res;
        logic [PW-1:0]       idx;
        res = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = r_head + PW'(i);
            if ((q != '0) && (CW'(i) < r_count) && (r_rd[idx] == q)) begin
                res = {1'b1, r_data[idx]};
            end
        end
        return res;
    endfunction

    logic [DATA_WIDTH:0] w_q1;
    logic [DATA_WIDTH:0] w_q2;

    // Forward pending data for both read ports from queue state only.
    always_comb begin
        w_q1 = f_lookup(q1_ad);
        w_q2 = f_lookup(q2_ad);
    end

    assign q1_hit  = w_q1[DATA_WIDTH];
    assign q1_data = w_q1[DATA_WIDTH-1:0];
    assign q2_hit  = w_q2[DATA_WIDTH];
    assign q2_data = w_q2[DATA_WIDTH-1:0];
`endif

endmodule
